vball_sync_decoder: RTL and testbench

//  Receive-side counterpart of the VBall video timing generator. Samples hs/vs/hb/vb at pixel

---
 rtl/vball_sync_decoder_if.sv | 37 +++
 rtl/vball_sync_decoder.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_vball_sync_decoder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/vball_sync_decoder_if.sv
// Video timing bundle between the VBall core output and its sync decoder.
// Latency: n/a (wires only).
// Backpressure: none; the stream is paced by ce_pix and cannot be stalled.
//
// Ports / signals:
//   ce_pix, hs_in, vs_in, hb_in, vb_in    raw timing from the core (master drives)
//   x, y, de                              recovered raster position (decoder drives)
//   h_total, v_total, h_active, v_active  geometry of the last complete frame
//   frame_stb, locked                     measurement update pulse and lock flag
interface vball_sync_decoder_if;
  logic       ce_pix;
  logic       hs_in;
  logic       vs_in;
  logic       hb_in;
  logic       vb_in;
  logic [9:0] x;
  logic [9:0] y;
  logic       de;
  logic [9:0] h_total;
  logic [9:0] v_total;
  logic [9:0] h_active;
  logic [9:0] v_active;
  logic       frame_stb;
  logic       locked;

  // Video source side.
  modport master (
    output ce_pix, hs_in, vs_in, hb_in, vb_in,
    input  x, y, de, h_total, v_total, h_active, v_active, frame_stb, locked
  );

  // Decoder side.
  modport slave (
    input  ce_pix, hs_in, vs_in, hb_in, vb_in,
    output x, y, de, h_total, v_total, h_active, v_active, frame_stb, locked
  );
endinterface

// File: rtl/vball_sync_decoder.sv
// Recovers raster position and frame geometry from VBall hs/vs/hb/vb timing; declares lock.
// Latency: x/y/de and measurements are registered, visible the clk after the ce_pix tick.
// Backpressure: none; every ce_pix tick is consumed, outputs hold while ce_pix is low.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high; returns every register and output to 0 / SEARCH
//   vid        slave side of vball_sync_decoder_if (timing in, position/geometry/lock out)
module vball_sync_decoder #(
  parameter bit SYNC_ACTIVE_LOW = 1'b1,  // 1: hs/vs pulse low
  parameter int LOCK_FRAMES     = 3,     // identical frames needed for lock
  parameter int V_TIMEOUT       = 1023   // lines without vs before giving up
) (
  input logic                 clk,
  input logic                 reset,
  vball_sync_decoder_if.slave vid
);

  localparam logic [9:0] CMAX = 10'd1023;
  localparam logic [9:0] VTO  = 10'(V_TIMEOUT);
  // match counter only needs to reach LOCK_FRAMES-1
  localparam int             MW        = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
  localparam logic [MW-1:0]  MATCH_TGT = MW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input sampling and edge detection (only on ce ticks)
  // ---------------------------------------------------------------------------
  logic hs_act, vs_act;
  logic hs_act_q, hs_act_d;
  logic vs_act_q, vs_act_d;
  logic hb_q, hb_d;
  logic vb_q, vb_d;
  logic hs_edge, vs_edge, hb_fall, vb_fall;

  // Normalise sync polarity so "1" always means "inside the sync pulse".
  assign hs_act = SYNC_ACTIVE_LOW ? ~vid.hs_in : vid.hs_in;
  assign vs_act = SYNC_ACTIVE_LOW ? ~vid.vs_in : vid.vs_in;

  assign hs_edge = vid.ce_pix & hs_act & ~hs_act_q;
  assign vs_edge = vid.ce_pix & vs_act & ~vs_act_q;
  assign hb_fall = vid.ce_pix & hb_q & ~vid.hb_in;
  assign vb_fall = vid.ce_pix & vb_q & ~vid.vb_in;

  always_comb begin
    hs_act_d = hs_act_q;
    vs_act_d = vs_act_q;
    hb_d     = hb_q;
    vb_d     = vb_q;
    if (vid.ce_pix) begin
      hs_act_d = hs_act;
      vs_act_d = vs_act;
      hb_d     = vid.hb_in;
      vb_d     = vid.vb_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Line / frame counters
  // ---------------------------------------------------------------------------
  logic [9:0] hc_q, hc_d;          // ce ticks since last hs edge
  logic [9:0] hc_lat_q, hc_lat_d;  // length of last complete line
  logic [9:0] ha_q, ha_d;          // non-hblank ticks since last hs edge
  logic [9:0] ha_lat_q, ha_lat_d;
  logic [9:0] vc_q, vc_d;          // hs edges since last vs edge
  logic [9:0] vac_q, vac_d;        // of which with vb low
  logic [9:0] hc_inc, ha_inc, vc_hs, vac_hs;

  // The hs edge tick closes the old line, so it is counted into the latched
  // value and the new line starts at 0.
  assign hc_inc = (hc_q == CMAX) ? CMAX : hc_q + 10'd1;
  assign ha_inc = (!vid.hb_in && ha_q != CMAX) ? ha_q + 10'd1 : ha_q;

  // Line counts after this tick's hs edge: a coincident vs edge sees the hs first.
  assign vc_hs  = (hs_edge && vc_q != CMAX) ? vc_q + 10'd1 : vc_q;
  assign vac_hs = (hs_edge && !vid.vb_in && vac_q != CMAX) ? vac_q + 10'd1 : vac_q;

  always_comb begin
    hc_d     = hc_q;
    hc_lat_d = hc_lat_q;
    ha_d     = ha_q;
    ha_lat_d = ha_lat_q;
    vc_d     = vc_q;
    vac_d    = vac_q;
    if (vid.ce_pix) begin
      if (hs_edge) begin
        hc_lat_d = hc_inc;
        hc_d     = '0;
        ha_lat_d = ha_inc;
        ha_d     = '0;
      end else begin
        hc_d = hc_inc;
        ha_d = ha_inc;
      end
      vc_d  = vc_hs;
      vac_d = vac_hs;
      if (vs_edge) begin
        vc_d  = '0;
        vac_d = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame measurements, published on every vs leading edge
  // ---------------------------------------------------------------------------
  logic [9:0] h_total_q, h_total_d;
  logic [9:0] v_total_q, v_total_d;
  logic [9:0] h_active_q, h_active_d;
  logic [9:0] v_active_q, v_active_d;
  logic       frame_stb_q, frame_stb_d;

  always_comb begin
    h_total_d   = h_total_q;
    v_total_d   = v_total_q;
    h_active_d  = h_active_q;
    v_active_d  = v_active_q;
    frame_stb_d = vs_edge;
    if (vs_edge) begin
      h_total_d  = hc_lat_d;
      v_total_d  = vc_hs;
      h_active_d = ha_lat_d;
      v_active_d = vac_hs;
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [MW-1:0] match_q, match_d;
  logic          prev_vld_q, prev_vld_d;  // previous frame is a real, complete frame
  logic          locked_q, locked_d;
  logic          same_geom, ovf;
  logic [MW-1:0] match_inc;

  // New frame geometry vs. the frame currently published on the outputs.
  assign same_geom = (hc_lat_d == h_total_q) && (vc_hs == v_total_q);
  assign match_inc = match_q + MW'(1);

  // A saturated line counter means hs vanished; too many lines means vs vanished.
  // A vs edge on the same tick restarts the frame, so it is not a timeout.
  assign ovf = vid.ce_pix & ((hc_d == CMAX) | (~vs_edge & (vc_hs >= VTO)));

  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    prev_vld_d = prev_vld_q;
    unique case (state_q)
      ST_SEARCH: begin
        // The frame ending here began mid-stream; never compare against it.
        if (vs_edge) begin
          state_d    = ST_TRAIN;
          match_d    = '0;
          prev_vld_d = 1'b0;
        end
      end
      ST_TRAIN: begin
        if (vs_edge) begin
          prev_vld_d = 1'b1;
          if (prev_vld_q && same_geom) begin
            match_d = match_inc;
            if (match_inc >= MATCH_TGT) state_d = ST_LOCKED;
          end else begin
            match_d = '0;
            if (MATCH_TGT == '0) state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (vs_edge && !same_geom) begin
          state_d = ST_TRAIN;
          match_d = '0;
        end
      end
      default: begin
        state_d = ST_SEARCH;
        match_d = '0;
      end
    endcase
    if (ovf) begin
      state_d = ST_SEARCH;
      match_d = '0;
    end
  end

  // Registered from the next state so lock changes line up with frame_stb.
  assign locked_d = (state_d == ST_LOCKED);

  // ---------------------------------------------------------------------------
  // Raster position
  // ---------------------------------------------------------------------------
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       de_q, de_d;
  logic       first_q, first_d;  // next active line is line 0
  logic       arm;

  // vb may fall on the same tick as hb; arming and using it then must coincide.
  assign arm = vb_fall | first_q;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    de_d    = de_q;
    first_d = first_q;
    if (vid.ce_pix) begin
      de_d = ~vid.hb_in & ~vid.vb_in;
      if (hb_fall) begin
        x_d = '0;
      end else if (!vid.hb_in && x_q != CMAX) begin
        x_d = x_q + 10'd1;
      end
      if (hb_fall) begin
        if (arm) begin
          y_d     = '0;
          first_d = 1'b0;
        end else if (!vid.vb_in && y_q != CMAX) begin
          y_d = y_q + 10'd1;
        end
      end else if (vb_fall) begin
        first_d = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_act_q    <= 1'b0;
      vs_act_q    <= 1'b0;
      hb_q        <= 1'b0;
      vb_q        <= 1'b0;
      hc_q        <= '0;
      hc_lat_q    <= '0;
      ha_q        <= '0;
      ha_lat_q    <= '0;
      vc_q        <= '0;
      vac_q       <= '0;
      h_total_q   <= '0;
      v_total_q   <= '0;
      h_active_q  <= '0;
      v_active_q  <= '0;
      frame_stb_q <= 1'b0;
      state_q     <= ST_SEARCH;
      match_q     <= '0;
      prev_vld_q  <= 1'b0;
      locked_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      de_q        <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      hs_act_q    <= hs_act_d;
      vs_act_q    <= vs_act_d;
      hb_q        <= hb_d;
      vb_q        <= vb_d;
      hc_q        <= hc_d;
      hc_lat_q    <= hc_lat_d;
      ha_q        <= ha_d;
      ha_lat_q    <= ha_lat_d;
      vc_q        <= vc_d;
      vac_q       <= vac_d;
      h_total_q   <= h_total_d;
      v_total_q   <= v_total_d;
      h_active_q  <= h_active_d;
      v_active_q  <= v_active_d;
      frame_stb_q <= frame_stb_d;
      state_q     <= state_d;
      match_q     <= match_d;
      prev_vld_q  <= prev_vld_d;
      locked_q    <= locked_d;
      x_q         <= x_d;
      y_q         <= y_d;
      de_q        <= de_d;
      first_q     <= first_d;
    end
  end

  assign vid.x         = x_q;
  assign vid.y         = y_q;
  assign vid.de        = de_q;
  assign vid.h_total   = h_total_q;
  assign vid.v_total   = v_total_q;
  assign vid.h_active  = h_active_q;
  assign vid.v_active  = v_active_q;
  assign vid.frame_stb = frame_stb_q;
  assign vid.locked    = locked_q;

endmodule

// File: tb/tb_vball_sync_decoder.sv
// Directed bench for vball_sync_decoder on a reduced raster (40x24 / 37x23,
// 24x16 active, hs 4 ticks, vs 3 lines) so every scenario fits a short run.
module tb_vball_sync_decoder;

  localparam int HA  = 24;
  localparam int VA  = 16;
  localparam int HS0 = 28;
  localparam int HSW = 4;
  localparam int VS0 = 19;
  localparam int VSW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vball_sync_decoder_if vif ();

  vball_sync_decoder #(
    .SYNC_ACTIVE_LOW(1'b1),
    .LOCK_FRAMES(3),
    .V_TIMEOUT(1023)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .vid  (vif.slave)
  );

  int errors = 0;
  int checks = 0;

  int H = 40, V = 24, h = 0, v = 0, ce_div = 1;
  bit vs_en = 1'b1, xy_chk = 1'b0, de_arm = 1'b0;
  bit hs_prev_tb = 1'b0, vs_prev_tb = 1'b0;
  int stb_cnt, lock_stb, drop_stb, relock_stb, first_stb_line, hs_since_vs, de_cnt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic clear_stats();
    stb_cnt = 0; lock_stb = 0; drop_stb = 0; relock_stb = 0;
    first_stb_line = -1; de_cnt = 0; de_arm = 1'b0;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_eq({pfx, "_x"}, 32'(vif.x), 0);
    check_eq({pfx, "_y"}, 32'(vif.y), 0);
    check_eq({pfx, "_de"}, 32'(vif.de), 0);
    check_eq({pfx, "_h_total"}, 32'(vif.h_total), 0);
    check_eq({pfx, "_v_total"}, 32'(vif.v_total), 0);
    check_eq({pfx, "_h_active"}, 32'(vif.h_active), 0);
    check_eq({pfx, "_v_active"}, 32'(vif.v_active), 0);
    check_eq({pfx, "_frame_stb"}, 32'(vif.frame_stb), 0);
    check_eq({pfx, "_locked"}, 32'(vif.locked), 0);
  endtask

  task automatic check_geom(input string pfx, input int ht, input int vt);
    check_eq({pfx, "_h_total"}, 32'(vif.h_total), ht);
    check_eq({pfx, "_v_total"}, 32'(vif.v_total), vt);
    check_eq({pfx, "_h_active"}, 32'(vif.h_active), HA);
    check_eq({pfx, "_v_active"}, 32'(vif.v_active), VA);
  endtask

  // Sampled once per clk, 1 time unit after the rising edge.
  task automatic monitor();
    logic [31:0] act, exp;
    if (vif.frame_stb) begin
      stb_cnt++;
      if (stb_cnt == 1) first_stb_line = v;
      if (vif.locked && lock_stb == 0) lock_stb = stb_cnt;
      if (!vif.locked && drop_stb == 0) drop_stb = stb_cnt;
      if (vif.locked && drop_stb != 0 && relock_stb == 0) relock_stb = stb_cnt;
      if (de_arm) check_eq("de_per_frame", 32'(de_cnt), HA * VA);
      de_arm = xy_chk;
      de_cnt = 0;
    end
    if (xy_chk) begin
      if (h < HA && v < VA) begin
        act = {11'd0, vif.de, vif.x, vif.y};
        exp = {11'd0, 1'b1, h[9:0], v[9:0]};
        check_eq("de_x_y", act, exp);
      end else begin
        check_eq("de_blank", 32'(vif.de), 0);
      end
    end
  endtask

  task automatic drive_pix(input bit hs_a, input bit vs_a, input bit hb, input bit vb);
    vif.hs_in = ~hs_a;
    vif.vs_in = ~vs_a;
    vif.hb_in = hb;
    vif.vb_in = vb;
    if (hs_a && !hs_prev_tb) hs_since_vs++;
    if (vs_a && !vs_prev_tb) hs_since_vs = 0;
    hs_prev_tb = hs_a;
    vs_prev_tb = vs_a;
    for (int k = 0; k < ce_div; k++) begin
      vif.ce_pix = (k == 0);
      @(posedge clk);
      #1;
      monitor();
      if (k == 0 && xy_chk && vif.de) de_cnt++;
    end
    vif.ce_pix = 1'b0;
  endtask

  task automatic run_pix();
    bit hs_a, vs_a;
    hs_a = (h >= HS0) && (h < HS0 + HSW);
    vs_a = vs_en && ((v > VS0) || (v == VS0 && h >= HS0))
                 && ((v < VS0 + VSW) || (v == VS0 + VSW && h < HS0));
    drive_pix(hs_a, vs_a, h >= HA, v >= VA);
    h++;
    if (h >= H) begin
      h = 0;
      v++;
      if (v >= V) v = 0;
    end
  endtask

  task automatic run_frames(input int n);
    repeat (n) begin
      run_pix();
      while (h != 0 || v != 0) run_pix();
    end
  endtask

  task automatic pulse_reset();
    vif.ce_pix = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    hs_prev_tb = 1'b0;
    vs_prev_tb = 1'b0;
  endtask

  initial begin
    bit done;
    reset      = 1'b1;
    vif.ce_pix = 1'b0;
    vif.hs_in  = 1'b1;
    vif.vs_in  = 1'b1;
    vif.hb_in  = 1'b1;
    vif.vb_in  = 1'b1;
    hs_since_vs = 0;
    repeat (3) @(posedge clk);
    #1;
    pulse_reset();
    check_outputs_zero("reset");

    // Normal 40x24 raster from power-up.
    clear_stats();
    run_frames(5);
    check_eq("t1_first_stb_line", 32'(first_stb_line), VS0);
    check_eq("t1_lock_stb", 32'(lock_stb), 4);
    check_eq("t1_locked", 32'(vif.locked), 1);
    check_geom("t1", 40, 24);

    // Switch to 37x23 in the middle of a locked frame.
    clear_stats();
    while (!(v == 10 && h == 0)) run_pix();
    H = 37;
    V = 23;
    run_frames(5);
    check_eq("t3_drop_stb", 32'(drop_stb), 1);
    check_eq("t3_relock_stb", 32'(relock_stb), 4);
    check_geom("t3", 37, 23);

    // Sync loss: hs keeps running on short lines, vs never comes.
    clear_stats();
    done = 1'b0;
    for (int n = 0; n < 1100 && !done; n++) begin
      for (int t = 0; t < 8; t++) drive_pix(t < 2, 1'b0, 1'b1, 1'b1);
      if (hs_since_vs == 1022) check_eq("t4_locked_before_timeout", 32'(vif.locked), 1);
      if (hs_since_vs == 1023) begin
        check_eq("t4_locked_after_timeout", 32'(vif.locked), 0);
        done = 1'b1;
      end
    end
    check_eq("t4_timeout_reached", 32'(done), 1);
    check_eq("t4_no_frame_stb", 32'(stb_cnt), 0);
    check_geom("t4_hold", 37, 23);

    // Recover on 40x24, then reset at line 10 of a locked frame.
    H = 40; V = 24; h = 0; v = 0;
    clear_stats();
    run_frames(5);
    check_eq("t6_relock_from_search", 32'(lock_stb), 4);
    while (!(v == 10 && h == 0)) run_pix();
    pulse_reset();
    check_outputs_zero("t6_reset");
    clear_stats();
    run_frames(5);
    check_eq("t6_first_stb_line", 32'(first_stb_line), VS0);
    check_eq("t6_lock_stb", 32'(lock_stb), 4);
    check_geom("t6", 40, 24);

    // ce_pix every 4th clk: position and geometry in ticks, not clocks.
    clear_stats();
    ce_div = 4;
    xy_chk = 1'b1;
    run_frames(3);
    xy_chk = 1'b0;
    ce_div = 1;
    check_eq("t5_de_frames_checked", 32'(stb_cnt), 3);
    check_eq("t5_locked", 32'(vif.locked), 1);
    check_geom("t5", 40, 24);

    // ycmode 37x23 from a fresh reset.
    pulse_reset();
    H = 37; V = 23; h = 0; v = 0;
    clear_stats();
    run_frames(5);
    check_eq("t2_lock_stb", 32'(lock_stb), 4);
    check_geom("t2", 37, 23);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
